// File: rtl/video_unit_pipelined_if.sv
// Framebuffer read port between the scanout block (master) and video RAM (slave).
// Protocol: there is no valid/ready; the master drives ram_addr every cycle and the RAM returns the byte for it on ram_data exactly one cycle later.
interface video_unit_pipelined_if #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_data;

    modport master (output ram_addr, input ram_data);
    modport slave  (input ram_addr, output ram_data);
endinterface

// File: rtl/video_unit_pipelined.sv
// VGA scanout for the rotated 1bpp framebuffer: timing counters, a centred and replicated image window,
// a two-stage fetch/colour pipeline with sync kept aligned, and mid-screen / vblank interrupt pulses.
module video_unit_pipelined #(
    parameter int RAM_SIZE       = 8192,
    parameter int RAM_ADDR_WIDTH = $clog2(RAM_SIZE),
    parameter int XLEN           = 8,
    parameter int FB_BASE        = 'h400,
    parameter int H_ACTIVE       = 640,
    parameter int H_FP           = 16,
    parameter int H_SYNC_W       = 96,
    parameter int H_BP           = 48,
    parameter int V_ACTIVE       = 480,
    parameter int V_FP           = 10,
    parameter int V_SYNC_W       = 2,
    parameter int V_BP           = 33,
    parameter bit SYNC_POL       = 1'b0,
    parameter int SCALE          = 1,
    parameter int IMG_W          = 224,
    parameter int IMG_H          = 256,
    parameter int X_OFF          = 208,
    parameter int Y_OFF          = 112,
    parameter int MID_LINE       = 128,
    parameter int VBL_LINE       = V_ACTIVE,
    parameter int RED_LO         = 32,
    parameter int RED_HI         = 64,
    parameter int GRN_LO         = 184,
    parameter int GRN_HI         = 240
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   overlay_en,
    video_unit_pipelined_if.master ram_bus,
    output logic [3:0]             vga_red,
    output logic [3:0]             vga_green,
    output logic [3:0]             vga_blue,
    output logic                   h_sync,
    output logic                   v_sync,
    output logic                   mid_screen,
    output logic                   vblank
);

    localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC_W + H_BP;
    localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC_W + V_BP;
    localparam int XW        = $clog2(H_TOTAL);
    localparam int YW        = $clog2(V_TOTAL);
    localparam int UW        = (IMG_W > 2) ? $clog2(IMG_W) : 1;
    // v is at least 8 bits wide so the column-byte index v[7:3] always exists.
    localparam int VW        = ($clog2(IMG_H) > 8) ? $clog2(IMG_H) : 8;
    localparam int H_SYNC_LO = H_ACTIVE + H_FP;
    localparam int H_SYNC_HI = H_ACTIVE + H_FP + H_SYNC_W;
    localparam int V_SYNC_LO = V_ACTIVE + V_FP;
    localparam int V_SYNC_HI = V_ACTIVE + V_FP + V_SYNC_W;
    localparam int WIN_X_HI  = X_OFF + IMG_W * SCALE;
    localparam int WIN_Y_HI  = Y_OFF + IMG_H * SCALE;

    typedef enum logic [1:0] {
        BAND_WHITE = 2'd0,
        BAND_RED   = 2'd1,
        BAND_GREEN = 2'd2
    } band_e;

    // Timing counters
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;

    // Stage 1: window / row info travelling alongside the RAM read
    logic          win1_q, win1_d;
    logic [2:0]    vlo1_q, vlo1_d;
    band_e         band1_q, band1_d;
    logic          hs1_q, hs1_d;
    logic          vs1_q, vs1_d;

    // Stage 2: registered pins
    logic [11:0]   colour_q, colour_d;
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic          mid_q, mid_d;
    logic          vbl_q, vbl_d;

    // Stage 0 combinational terms
    logic                      active_s;
    logic                      win_s;
    logic [UW-1:0]             u_s;
    logic [VW-1:0]             v_s;
    band_e                     band_s;
    logic                      hs0_s;
    logic                      vs0_s;
    logic [RAM_ADDR_WIDTH-1:0] ram_addr_s;
    logic [XLEN-1:0]           pix_byte;
    logic                      pixel_s;

    // Counter advance; the pulses are decoded from the next position so they
    // line up with the cycle in which the counters hold (0, line).
    always_comb begin
        x_d = x_q + 1'b1;
        y_d = y_q;
        if (x_q == XW'(H_TOTAL - 1)) begin
            x_d = '0;
            y_d = (y_q == YW'(V_TOTAL - 1)) ? '0 : y_q + 1'b1;
        end
        mid_d = (x_d == '0) && (y_d == YW'(MID_LINE));
        vbl_d = (x_d == '0) && (y_d == YW'(VBL_LINE));
    end

    // Stage 0: window decode, image coordinates and fetch address
    always_comb begin
        active_s = (int'(x_q) < H_ACTIVE) && (int'(y_q) < V_ACTIVE);
        win_s    = active_s
                   && (int'(x_q) >= X_OFF) && (int'(x_q) < WIN_X_HI)
                   && (int'(y_q) >= Y_OFF) && (int'(y_q) < WIN_Y_HI);
        u_s      = UW'((int'(x_q) - X_OFF) / SCALE);
        v_s      = VW'((int'(y_q) - Y_OFF) / SCALE);

        // Column-major, rotated framebuffer: 32 bytes per image column, top row in the last byte.
        ram_addr_s = RAM_ADDR_WIDTH'(FB_BASE);
        if (win_s) begin
            ram_addr_s = RAM_ADDR_WIDTH'(FB_BASE + 32 * int'(u_s) + 31 - int'(v_s[7:3]));
        end

        band_s = BAND_WHITE;
        if ((int'(v_s) >= RED_LO) && (int'(v_s) < RED_HI)) begin
            band_s = BAND_RED;
        end else if ((int'(v_s) >= GRN_LO) && (int'(v_s) < GRN_HI)) begin
            band_s = BAND_GREEN;
        end

        hs0_s = ((int'(x_q) >= H_SYNC_LO) && (int'(x_q) < H_SYNC_HI)) ? SYNC_POL : ~SYNC_POL;
        vs0_s = ((int'(y_q) >= V_SYNC_LO) && (int'(y_q) < V_SYNC_HI)) ? SYNC_POL : ~SYNC_POL;

        win1_d  = win_s;
        vlo1_d  = v_s[2:0];
        band1_d = band_s;
        hs1_d   = hs0_s;
        vs1_d   = vs0_s;
    end

    assign ram_bus.ram_addr = ram_addr_s;
    assign pix_byte         = ram_bus.ram_data;

    // Stage 1: pick the bit for this row and colour it
    always_comb begin
        pixel_s  = pix_byte[3'd7 - vlo1_q];
        colour_d = 12'h000;
        if (win1_q && pixel_s) begin
            colour_d = 12'hFFF;
            if (overlay_en) begin
                case (band1_q)
                    BAND_RED:   colour_d = 12'hF00;
                    BAND_GREEN: colour_d = 12'h0F0;
                    default:    colour_d = 12'hFFF;
                endcase
            end
        end
        hs_d = hs1_q;
        vs_d = vs1_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_q      <= '0;
            y_q      <= '0;
            win1_q   <= 1'b0;
            vlo1_q   <= '0;
            band1_q  <= BAND_WHITE;
            hs1_q    <= ~SYNC_POL;
            vs1_q    <= ~SYNC_POL;
            colour_q <= 12'h000;
            hs_q     <= ~SYNC_POL;
            vs_q     <= ~SYNC_POL;
            mid_q    <= 1'b0;
            vbl_q    <= 1'b0;
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            win1_q   <= win1_d;
            vlo1_q   <= vlo1_d;
            band1_q  <= band1_d;
            hs1_q    <= hs1_d;
            vs1_q    <= vs1_d;
            colour_q <= colour_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            mid_q    <= mid_d;
            vbl_q    <= vbl_d;
        end
    end

    assign vga_red    = colour_q[11:8];
    assign vga_green  = colour_q[7:4];
    assign vga_blue   = colour_q[3:0];
    assign h_sync     = hs_q;
    assign v_sync     = vs_q;
    assign mid_screen = mid_q;
    assign vblank     = vbl_q;

endmodule
